// File: rtl/clock_enable_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators emit one-cycle
// enables at refclk*inc/2^ACC_W. Define CLOCK_ENABLE_GEN_SQUARE_EN to add the clk_out square waves.
module clock_enable_gen #(
    parameter int unsigned      NUM_CH      = 2,
    parameter int unsigned      ACC_W       = 32,
    parameter int unsigned      LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0] INC_RESET   = ACC_W'(274877907),
    localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] en_out,
`ifdef CLOCK_ENABLE_GEN_SQUARE_EN
    output logic [NUM_CH-1:0] clk_out,
`endif
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {StSettle, StRun, StPending} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CH_W-1:0]    pend_ch_q;
    logic [ACC_W-1:0]   pend_inc_q;
    logic               locked_q;
    logic               ready_q;

    logic [ACC_W-1:0]   acc_q [NUM_CH];
    logic [ACC_W-1:0]   acc_d [NUM_CH];
    logic [ACC_W-1:0]   inc_q [NUM_CH];
    logic [ACC_W-1:0]   inc_d [NUM_CH];
    logic [NUM_CH-1:0]  carry;
    logic [NUM_CH-1:0]  en_q;
    logic               apply;
    logic               cfg_ch_ok;

    assign cfg_ch_ok = 32'(cfg_ch) < NUM_CH;

    // A stopped target (inc == 0) never carries, so it takes the new increment immediately.
    always_comb begin
        apply = 1'b0;
        carry = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            {carry[c], acc_d[c]} = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            inc_d[c] = inc_q[c];
            if (state_q == StPending && pend_ch_q == CH_W'(c) &&
                (carry[c] || inc_q[c] == '0)) begin
                apply    = 1'b1;
                inc_d[c] = pend_inc_q;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                inc_q[c] <= INC_RESET;
            end
            en_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= acc_d[c];
                inc_q[c] <= inc_d[c];
            end
            en_q <= carry;
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q    <= StSettle;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            ready_q    <= 1'b0;
            pend_ch_q  <= '0;
            pend_inc_q <= '0;
        end else begin
            unique case (state_q)
                StSettle: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_q  <= StRun;
                        locked_q <= 1'b1;
                        ready_q  <= 1'b1;
                    end
                end
                StRun: begin
                    // Out-of-range channels complete the handshake but are dropped.
                    if (cfg_valid && ready_q && cfg_ch_ok) begin
                        pend_ch_q  <= cfg_ch;
                        pend_inc_q <= cfg_inc;
                        state_q    <= StPending;
                        ready_q    <= 1'b0;
                    end
                end
                StPending: begin
                    if (apply) begin
                        state_q  <= StSettle;
                        cnt_q    <= '0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StSettle;
                    cnt_q    <= '0;
                    locked_q <= 1'b0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign en_out    = en_q;
    assign locked    = locked_q;
    assign cfg_ready = ready_q;

`ifdef CLOCK_ENABLE_GEN_SQUARE_EN
    always_comb begin
        clk_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            clk_out[c] = acc_q[c][ACC_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen (3 channels, 8-bit accumulators, 4-cycle settle, inc 64).
module tb_clock_enable_gen;

    logic       refclk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic [2:0] en_out;
`ifdef CLOCK_ENABLE_GEN_SQUARE_EN
    logic [2:0] clk_out;
`endif
    logic       locked;

    int checks   = 0;
    int failures = 0;

    clock_enable_gen #(
        .NUM_CH     (3),
        .ACC_W      (8),
        .LOCK_CYCLES(4),
        .INC_RESET  (8'd64)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .en_out   (en_out),
`ifdef CLOCK_ENABLE_GEN_SQUARE_EN
        .clk_out  (clk_out),
`endif
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample away from it.
    task automatic step(input string tag, input logic [2:0] e_en, input logic e_lk,
                        input logic e_rd);
        @(posedge refclk);
        #1;
        check({tag, "_en"}, 8'(en_out), 8'(e_en));
        check({tag, "_locked"}, 8'(locked), 8'(e_lk));
        check({tag, "_ready"}, 8'(cfg_ready), 8'(e_rd));
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_inc   = 8'd0;
        repeat (2) @(posedge refclk);
        #1;
        check("reset_en", 8'(en_out), 8'h00);
        check("reset_locked", 8'(locked), 8'h00);
        check("reset_ready", 8'(cfg_ready), 8'h00);
`ifdef CLOCK_ENABLE_GEN_SQUARE_EN
        check("reset_clk", 8'(clk_out), 8'h00);
`endif
        rst = 1'b1;

        step("rel1", 3'b000, 1'b0, 1'b0);
        step("rel2", 3'b000, 1'b0, 1'b0);
        step("rel3", 3'b000, 1'b0, 1'b0);
        step("rel4", 3'b111, 1'b1, 1'b1);
        step("run5", 3'b000, 1'b1, 1'b1);

        // ch1 -> 128 while acc1 = 64; applies at the ch1 wrap on edge 8
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd128;
        step("hs6", 3'b000, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        step("pend7", 3'b000, 1'b1, 1'b0);
        step("apply8", 3'b111, 1'b0, 1'b0);
        step("set9", 3'b000, 1'b0, 1'b0);
        step("set10", 3'b010, 1'b0, 1'b0);
        step("set11", 3'b000, 1'b0, 1'b0);
        step("lock12", 3'b111, 1'b1, 1'b1);
        step("run13", 3'b000, 1'b1, 1'b1);

        // ch2 -> 0: stops at its wrap on edge 16
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd0;
        step("hs14", 3'b010, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        step("pend15", 3'b000, 1'b1, 1'b0);
        step("stop16", 3'b111, 1'b0, 1'b0);
        step("set17", 3'b000, 1'b0, 1'b0);
        step("set18", 3'b010, 1'b0, 1'b0);
        step("set19", 3'b000, 1'b0, 1'b0);
        step("lock20", 3'b011, 1'b1, 1'b1);
        step("run21", 3'b000, 1'b1, 1'b1);

        // ch2 -> 32 from stopped: applies on first pending edge, then wraps every 8
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd32;
        step("hs22", 3'b010, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        step("apply23", 3'b000, 1'b0, 1'b0);
        step("set24", 3'b011, 1'b0, 1'b0);
        step("set25", 3'b000, 1'b0, 1'b0);
        step("set26", 3'b010, 1'b0, 1'b0);
        step("lock27", 3'b000, 1'b1, 1'b1);
        step("run28", 3'b011, 1'b1, 1'b1);

        // out-of-range channel is discarded without losing ready
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd200;
        step("disc29", 3'b000, 1'b1, 1'b1);
        step("disc30", 3'b010, 1'b1, 1'b1);
        cfg_valid = 1'b0;
        step("ch2p31", 3'b100, 1'b1, 1'b1);
        step("run32", 3'b011, 1'b1, 1'b1);
        step("run33", 3'b000, 1'b1, 1'b1);

        // reset while a ch0 retune is pending
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd128;
        step("hs34", 3'b010, 1'b1, 1'b0);
        cfg_valid = 1'b0;
        rst = 1'b0;
        step("rst35", 3'b000, 1'b0, 1'b0);
        step("rst36", 3'b000, 1'b0, 1'b0);
        rst = 1'b1;

        // all channels back at inc 64, pending request gone
        for (int r = 1; r <= 8; r++) begin
            step($sformatf("post%0d", r), (r % 4 == 0) ? 3'b111 : 3'b000,
                 (r >= 4) ? 1'b1 : 1'b0, (r >= 4) ? 1'b1 : 1'b0);
`ifdef CLOCK_ENABLE_GEN_SQUARE_EN
            check($sformatf("post%0d_clk", r), 8'(clk_out),
                  (r % 4 == 2 || r % 4 == 3) ? 8'h07 : 8'h00);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_enable_gen.md
# clock_enable_gen

Parametrised multi-channel fractional clock-enable generator for the transceiver datapath. It succeeds the fixed single-output PLL wrapper and runs entirely in fabric. Each channel runs a phase accumulator off `refclk` and emits one-cycle enable pulses at `f_refclk * inc / 2^ACC_W`. Per-channel increments can be reprogrammed at runtime through a valid/ready port, and a `locked` flag reports frequency stability after reset and after every retune. Typical use is the 3.2 MHz transmitter symbol enable plus auxiliary rates.

## Interface
- `NUM_CH`, 2: number of channels, minimum 1.
- `ACC_W`, 32: accumulator and increment width.
- `LOCK_CYCLES`, 16: settle length in `refclk` cycles, minimum 1.
- `INC_RESET`, 274877907: increment loaded into every channel on reset (3.2 MHz from 50 MHz at `ACC_W`=32).
- `CH_W`: localparam, `NUM_CH>1 ? $clog2(NUM_CH) : 1`.

Ports:
- `refclk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  block accepts a config on `cfg_valid & cfg_ready`.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_inc`  in  ACC_W  new increment.
- `en_out`  out  NUM_CH  per-channel one-cycle enable pulses.
- `clk_out`  out  NUM_CH  per-channel square wave; present only with `CLOCK_ENABLE_GEN_SQUARE_EN`.
- `locked`  out  1  high when all channels are at their programmed rate.

## Operation
- Each channel has registers `acc[c]` and `inc[c]`. Every cycle it computes `{carry, acc[c]} <= acc[c] + inc[c]` and sets `en_out[c] <= carry`.
- `inc[c] = 0` stops the channel: `acc` holds and no pulses are produced.
- Reset (`rst` sampled low): all `acc` = 0, all `inc` = `INC_RESET`, `en_out` = 0, `locked` = 0, `cfg_ready` = 0, FSM = SETTLE, settle counter = 0, any pending request discarded.
- FSM states:
  - SETTLE: `locked`=0, `cfg_ready`=0. The counter increments each cycle. When it reaches `LOCK_CYCLES`, go to RUN.
  - RUN: `locked`=1, `cfg_ready`=1.
    - On a handshake with `cfg_ch < NUM_CH`, latch `cfg_ch`/`cfg_inc` as pending and go to PENDING.
    - On a handshake with `cfg_ch >= NUM_CH`, discard the request and stay in RUN.
  - PENDING: `locked`=1, `cfg_ready`=0. Apply the pending increment when the target channel produces a carry, or on the first PENDING cycle if its current `inc` is 0. Apply means `inc[ch] <= pending`, counter cleared, go to SETTLE.
- A carry on the target channel in the same cycle as the handshake does not count. The apply waits for the next carry. This keeps the retune phase-continuous at the wrap point.
- Non-target channels are never disturbed by config activity.
- `cfg_valid` while `cfg_ready` = 0 is ignored. The requester must hold its request.

## Timing
- `acc`, `en_out`, `locked`, `cfg_ready` and `clk_out` are all registered; there are no combinational input-to-output paths.
- After the first edge with `rst` high, `acc` = `INC_RESET`.
- `en_out[c]` rises one edge after the add that overflowed and stays high for exactly one cycle per wrap.
- Reset release: `locked` rises after `LOCK_CYCLES` edges with `rst` high.
- Apply at edge k (same edge as the target's `en_out` pulse):
  - the add at edge k+1 uses the new increment;
  - `locked` and `cfg_ready` are low from k to k+`LOCK_CYCLES`, then high again.
- Discarded request: `cfg_ready` stays high and no cycle is lost.

## Configuration
- `CLOCK_ENABLE_GEN_SQUARE_EN` defined: port `clk_out[c] = acc[c][ACC_W-1]` is present. Duty cycle is 50% for power-of-two ratios; for other ratios it is within one `refclk` period of 50%. A stopped channel holds its level.
- Not defined: `clk_out` port and logic are absent. `en_out` behaviour is identical in both builds.

## Test plan
Bench parameters: `NUM_CH`=3, `ACC_W`=8, `LOCK_CYCLES`=4, `INC_RESET`=64.
- Reset release -> `acc` sequence 64, 128, 192, 0. `en_out` = 3'b111 after edges 4, 8, 12. `locked` rises after edge 4. `cfg_ready` = 1 from edge 4.
- RUN; set ch1 `inc`=128 when `acc1`=64 -> `cfg_ready` drops next edge. Apply occurs at the ch1 wrap. ch1 then pulses every 2 cycles. `locked` is low for 4 cycles. ch0 and ch2 keep their 4-cycle pulses.
- Set ch2 `inc`=0, then later `inc`=32 -> ch2 stops at the wrap with `acc2` held at 0. The second config applies on the first PENDING cycle, and ch2 then pulses every 8 cycles.
- `cfg_ch`=3 with `cfg_valid` -> request discarded. `cfg_ready` and `locked` stay high and all channels are unchanged.
- `rst` low during PENDING -> pending request dropped. All `inc` return to 64 and `locked` = 0 until 4 edges after release.
- With `CLOCK_ENABLE_GEN_SQUARE_EN` defined and `inc`=64 -> `clk_out[0]` is low 2 cycles, high 2 cycles, repeating.
